buf_wr_arbiter: RTL

- Shares the single write port of the circular buffer controller between NUM_CLIENTS frame producers, e.g. several UART RX channels.
- Round-robin grants one client at a time, then runs the full buffer handshake: request, ack, result, stream, finish, ack.
- Generates the in-buffer write address itself.
- Sits between the producers and the controller's wr_* interface, in the same clock domain as that interface.

---
 rtl/buf_wr_arbiter_pkg.sv | 23 ++
 rtl/buf_wr_arbiter_rr_arbiter.sv | 33 +++
 rtl/buf_wr_arbiter.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/buf_wr_arbiter_pkg.sv
// Shared types for the buffer write-port arbiter: FSM state encoding and a
// constant-foldable ceil(log2) helper used to size indices and counters.
package buf_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_REQ_REL,
    ST_XFER,
    ST_FIN,
    ST_FIN_REL
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/buf_wr_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr_i,
// wrapping, returned both one-hot and as an index.
module rr_arbiter
  import buf_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS = 4,
  parameter int unsigned IDX_W       = (NUM_CLIENTS > 1) ? clog2(NUM_CLIENTS) : 1
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  logic [IDX_W-1:0]       ptr_i,
  output logic [NUM_CLIENTS-1:0] grant_o,
  output logic [IDX_W-1:0]       idx_o,
  output logic                   any_o
);

  int unsigned pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      pos = (32'(ptr_i) + i) % NUM_CLIENTS;
      if (!any_o && req_i[pos[IDX_W-1:0]]) begin
        any_o                   = 1'b1;
        grant_o[pos[IDX_W-1:0]] = 1'b1;
        idx_o                   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/buf_wr_arbiter.sv
// Round-robin arbiter sharing the buffer controller's write port between
// NUM_CLIENTS producers. Optional handshake watchdog: BUF_ARB_TIMEOUT_EN.
module buf_wr_arbiter
  import buf_arb_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [NUM_CLIENTS-1:0]            cli_req_i,
  output logic [NUM_CLIENTS-1:0]            cli_grant_o,
  input  logic [NUM_CLIENTS-1:0]            cli_valid_i,
  input  logic [NUM_CLIENTS-1:0]            cli_last_i,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] cli_data_i,
  output logic                              cli_ready_o,
  output logic [NUM_CLIENTS-1:0]            cli_done_o,
  output logic [NUM_CLIENTS-1:0]            cli_reject_o,
  output logic                              cli_trunc_o,
  output logic                              wr_req_o,
  output logic                              wr_finish_o,
  input  logic                              wr_req_ack_i,
  input  logic                              wr_req_result_i,
  input  logic                              wr_finish_ack_i,
`ifdef BUF_ARB_TIMEOUT_EN
  output logic                              err_o,
`endif
  output logic                              wr_en_o,
  output logic [DATA_WIDTH-1:0]             wr_data_o,
  output logic [ADDR_WIDTH-1:0]             wr_addr_o
);

  localparam int unsigned IDX_W = (NUM_CLIENTS > 1) ? clog2(NUM_CLIENTS) : 1;

  state_e                 state_q, state_d;
  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       gidx_q, gidx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [ADDR_WIDTH-1:0]  addr_cnt_q, addr_cnt_d;
  logic                   res_q, res_d;
  logic                   trunc_q, trunc_d;
  logic                   wr_req_q, wr_req_d;
  logic                   wr_fin_q, wr_fin_d;
  logic [NUM_CLIENTS-1:0] done_q, done_d;
  logic [NUM_CLIENTS-1:0] reject_q, reject_d;
  logic                   trunc_p_q, trunc_p_d;

  logic [NUM_CLIENTS-1:0] arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;
  logic [IDX_W-1:0]       next_idx;
  logic                   xfer, beat, sel_req, sel_last, go_fin;

`ifdef BUF_ARB_TIMEOUT_EN
  localparam int unsigned WAIT_W = clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  assign err_o = err_q;
`endif

  rr_arbiter #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .IDX_W      (IDX_W)
  ) u_rr (
    .req_i  (cli_req_i),
    .ptr_i  (rr_ptr_q),
    .grant_o(arb_grant),
    .idx_o  (arb_idx),
    .any_o  (arb_any)
  );

  assign next_idx = (gidx_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : gidx_q + 1'b1;
  assign xfer     = (state_q == ST_XFER);
  assign sel_req  = cli_req_i[gidx_q];
  assign sel_last = cli_last_i[gidx_q];
  assign beat     = xfer && cli_valid_i[gidx_q];
  assign go_fin   = (beat && (sel_last || (&addr_cnt_q))) || !sel_req;

  assign cli_grant_o  = grant_q;
  assign cli_ready_o  = xfer;
  assign cli_done_o   = done_q;
  assign cli_reject_o = reject_q;
  assign cli_trunc_o  = trunc_p_q;
  assign wr_req_o     = wr_req_q;
  assign wr_finish_o  = wr_fin_q;
  assign wr_en_o      = beat;
  assign wr_data_o    = xfer ? cli_data_i[gidx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign wr_addr_o    = addr_cnt_q;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    addr_cnt_d = addr_cnt_q;
    res_d      = res_q;
    trunc_d    = trunc_q;
    wr_req_d   = wr_req_q;
    wr_fin_d   = wr_fin_q;
    done_d     = '0;
    reject_d   = '0;
    trunc_p_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d  = arb_grant;
          gidx_d   = arb_idx;
          wr_req_d = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (wr_req_ack_i) begin
          res_d    = wr_req_result_i;
          wr_req_d = 1'b0;
          state_d  = ST_REQ_REL;
        end
      end
      ST_REQ_REL: begin
        if (!wr_req_ack_i) begin
          if (res_q) begin
            state_d = ST_XFER;
          end else begin
            reject_d = grant_q;
            rr_ptr_d = next_idx;
            grant_d  = '0;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_XFER: begin
        if (beat) addr_cnt_d = addr_cnt_q + 1'b1;
        if (beat && !sel_last && (&addr_cnt_q)) trunc_d = 1'b1;
        if (go_fin) begin
          wr_fin_d = 1'b1;
          state_d  = ST_FIN;
        end
      end
      ST_FIN: begin
        if (wr_finish_ack_i) begin
          wr_fin_d = 1'b0;
          state_d  = ST_FIN_REL;
        end
      end
      ST_FIN_REL: begin
        if (!wr_finish_ack_i) begin
          done_d     = grant_q;
          trunc_p_d  = trunc_q;
          addr_cnt_d = '0;
          trunc_d    = 1'b0;
          rr_ptr_d   = next_idx;
          grant_d    = '0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef BUF_ARB_TIMEOUT_EN
    // Watchdog expiry overrides whatever the handshake state decided above.
    err_d  = 1'b0;
    wait_d = '0;
    if (state_q inside {ST_REQ, ST_REQ_REL, ST_FIN, ST_FIN_REL}) begin
      if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
        wr_req_d   = 1'b0;
        wr_fin_d   = 1'b0;
        err_d      = 1'b1;
        reject_d   = grant_q;
        done_d     = '0;
        trunc_p_d  = 1'b0;
        addr_cnt_d = '0;
        trunc_d    = 1'b0;
        rr_ptr_d   = next_idx;
        grant_d    = '0;
        state_d    = ST_IDLE;
      end else if (state_d == state_q) begin
        wait_d = wait_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      addr_cnt_q <= '0;
      res_q      <= 1'b0;
      trunc_q    <= 1'b0;
      wr_req_q   <= 1'b0;
      wr_fin_q   <= 1'b0;
      done_q     <= '0;
      reject_q   <= '0;
      trunc_p_q  <= 1'b0;
`ifdef BUF_ARB_TIMEOUT_EN
      wait_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      addr_cnt_q <= addr_cnt_d;
      res_q      <= res_d;
      trunc_q    <= trunc_d;
      wr_req_q   <= wr_req_d;
      wr_fin_q   <= wr_fin_d;
      done_q     <= done_d;
      reject_q   <= reject_d;
      trunc_p_q  <= trunc_p_d;
`ifdef BUF_ARB_TIMEOUT_EN
      wait_q     <= wait_d;
      err_q      <= err_d;
`endif
    end
  end

endmodule
